// File: rtl/uart_rx_sample_loader.sv
// 8N1 UART receiver that pairs consecutive bytes into signed complex samples
// (even byte real, odd byte imaginary) and tags each with a frame-relative index.
module uart_rx_sample_loader #(
  parameter int N            = 256,
  parameter int CLKS_PER_BIT = 10,
  parameter int IDX_W        = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_i,
  input  logic                    clr_i,
  output logic signed [7:0]       data_re,
  output logic signed [7:0]       data_im,
  output logic                    sample_valid,
  output logic [IDX_W-1:0]        sample_idx,
  output logic                    frame_done,
  output logic                    byte_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_ok, byte_bad;

  logic             phase_im_q, phase_im_d;
  logic [7:0]       re_hold_q, re_hold_d;
  logic [7:0]       re_q, re_d, im_q, im_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Returning to IDLE at mid-stop re-arms half a bit before the next start edge.
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          state_d  = IDLE;
          byte_ok  = rx_s_q;
          byte_bad = !rx_s_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    phase_im_d = phase_im_q;
    re_hold_d  = re_hold_q;
    re_d       = re_q;
    im_d       = im_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    idx_d      = valid_q ? idx_q + 1'b1 : idx_q;
    if (clr_i) begin
      phase_im_d = 1'b0;
      idx_d      = '0;
    end else if (byte_ok) begin
      if (!phase_im_q) begin
        re_hold_d  = shift_q;
        phase_im_d = 1'b1;
      end else begin
        re_d       = re_hold_q;
        im_d       = shift_q;
        valid_d    = 1'b1;
        done_d     = (idx_d == IDX_LAST);
        phase_im_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      phase_im_q <= 1'b0;
      re_hold_q  <= '0;
      re_q       <= '0;
      im_q       <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      phase_im_q <= phase_im_d;
      re_hold_q  <= re_hold_d;
      re_q       <= re_d;
      im_q       <= im_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= byte_bad;
      idx_q      <= idx_d;
    end
  end

  assign data_re      = re_q;
  assign data_im      = im_q;
  assign sample_valid = valid_q;
  assign sample_idx   = idx_q;
  assign frame_done   = done_q;
  assign byte_err     = err_q;

endmodule

// File: tb/tb_uart_rx_sample_loader.sv
// Directed bench: one shared UART line drives an N=256 and an N=4 instance;
// a negedge monitor records every emitted sample for the scenario tasks to check.
module tb_uart_rx_sample_loader;

  localparam int CPB = 10;

  typedef struct {
    logic [7:0]  re;
    logic [7:0]  im;
    int unsigned idx;
    logic        fd;
  } samp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic clr = 1'b0;

  logic signed [7:0] re256, im256, re4, im4;
  logic              v256, fd256, err256, v4, fd4, err4;
  logic [7:0]        idx256;
  logic [1:0]        idx4;

  samp_t q256[$];
  samp_t q4[$];
  int errc256, errc4, fdc256, fdc4, orphan256, orphan4;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_rx_sample_loader #(.N(256), .CLKS_PER_BIT(CPB)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .rx_i(rx), .clr_i(clr),
    .data_re(re256), .data_im(im256), .sample_valid(v256),
    .sample_idx(idx256), .frame_done(fd256), .byte_err(err256)
  );

  uart_rx_sample_loader #(.N(4), .CLKS_PER_BIT(CPB)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rx_i(rx), .clr_i(clr),
    .data_re(re4), .data_im(im4), .sample_valid(v4),
    .sample_idx(idx4), .frame_done(fd4), .byte_err(err4)
  );

  always @(negedge clk) begin
    samp_t s;
    if (v256) begin
      s.re = re256; s.im = im256; s.idx = int'(idx256); s.fd = fd256;
      q256.push_back(s);
    end
    if (v4) begin
      s.re = re4; s.im = im4; s.idx = int'(idx4); s.fd = fd4;
      q4.push_back(s);
    end
    if (fd256) fdc256++;
    if (fd4) fdc4++;
    if (fd256 && !v256) orphan256++;
    if (fd4 && !v4) orphan4++;
    if (err256) errc256++;
    if (err4) errc4++;
  end

  task automatic clear_mon();
    q256.delete(); q4.delete();
    errc256 = 0; errc4 = 0; fdc256 = 0; fdc4 = 0; orphan256 = 0; orphan4 = 0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; clr = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (re256 !== 8'h00) begin fails++; $display("FAIL reset_re: got %h expected 00", re256); end
    checks++; if (im256 !== 8'h00) begin fails++; $display("FAIL reset_im: got %h expected 00", im256); end
    checks++; if (v256 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", v256); end
    checks++; if (idx256 !== 8'd0) begin fails++; $display("FAIL reset_idx: got %0d expected 0", idx256); end
    checks++; if (fd256 !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", fd256); end
    checks++; if (err256 !== 1'b0) begin fails++; $display("FAIL reset_byte_err: got %b expected 0", err256); end
    checks++; if ({v4, idx4, re4, im4} !== 19'd0) begin fails++; $display("FAIL reset_n4: got %h expected 0", {v4, idx4, re4, im4}); end
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_frame_256();
    pulse_clr();
    idle(20);
    clear_mon();
    for (int unsigned i = 0; i < 512; i++) send_byte(8'hFF, 1'b1);
    idle(20);
    checks++; if (q256.size() != 256) begin fails++; $display("FAIL frame_count256: got %0d expected 256", q256.size()); end
    for (int unsigned i = 0; i < 256 && i < q256.size(); i++) begin
      checks++;
      if (q256[i].re !== 8'hFF || q256[i].im !== 8'hFF || q256[i].idx != i || q256[i].fd !== (i == 255)) begin
        fails++;
        $display("FAIL frame_sample256[%0d]: got re=%h im=%h idx=%0d fd=%b expected re=ff im=ff idx=%0d fd=%b",
                 i, q256[i].re, q256[i].im, q256[i].idx, q256[i].fd, i, (i == 255));
      end
    end
    checks++; if (fdc256 != 1) begin fails++; $display("FAIL frame_done_count256: got %0d expected 1", fdc256); end
    checks++; if (orphan256 != 0) begin fails++; $display("FAIL frame_done_alone256: got %0d expected 0", orphan256); end
    checks++; if (errc256 != 0) begin fails++; $display("FAIL frame_byte_err256: got %0d expected 0", errc256); end
    checks++; if (q4.size() != 256) begin fails++; $display("FAIL frame_count4: got %0d expected 256", q4.size()); end
    for (int unsigned i = 0; i < 256 && i < q4.size(); i++) begin
      checks++;
      if (q4[i].re !== 8'hFF || q4[i].im !== 8'hFF || q4[i].idx != (i % 4) || q4[i].fd !== ((i % 4) == 3)) begin
        fails++;
        $display("FAIL frame_sample4[%0d]: got re=%h im=%h idx=%0d fd=%b expected re=ff im=ff idx=%0d fd=%b",
                 i, q4[i].re, q4[i].im, q4[i].idx, q4[i].fd, i % 4, ((i % 4) == 3));
      end
    end
    checks++; if (fdc4 != 64) begin fails++; $display("FAIL frame_done_count4: got %0d expected 64", fdc4); end
  endtask

  task automatic test_pairs_n4();
    logic [7:0]  bytes [10] = '{8'h01, 8'h80, 8'h7F, 8'hFE, 8'h03, 8'h04, 8'h05, 8'h06, 8'h11, 8'h22};
    int unsigned e_idx4 [5] = '{0, 1, 2, 3, 0};
    logic        e_fd4  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    pulse_clr();
    idle(20);
    clear_mon();
    for (int unsigned i = 0; i < 10; i++) send_byte(bytes[i], 1'b1);
    idle(20);
    checks++; if (q4.size() != 5) begin fails++; $display("FAIL pairs_count4: got %0d expected 5", q4.size()); end
    checks++; if (q256.size() != 5) begin fails++; $display("FAIL pairs_count256: got %0d expected 5", q256.size()); end
    for (int unsigned i = 0; i < 5 && i < q4.size(); i++) begin
      checks++;
      if (q4[i].re !== bytes[2*i] || q4[i].im !== bytes[2*i+1] || q4[i].idx != e_idx4[i] || q4[i].fd !== e_fd4[i]) begin
        fails++;
        $display("FAIL pairs_sample4[%0d]: got re=%h im=%h idx=%0d fd=%b expected re=%h im=%h idx=%0d fd=%b",
                 i, q4[i].re, q4[i].im, q4[i].idx, q4[i].fd, bytes[2*i], bytes[2*i+1], e_idx4[i], e_fd4[i]);
      end
    end
    for (int unsigned i = 0; i < 5 && i < q256.size(); i++) begin
      checks++;
      if (q256[i].re !== bytes[2*i] || q256[i].im !== bytes[2*i+1] || q256[i].idx != i || q256[i].fd !== 1'b0) begin
        fails++;
        $display("FAIL pairs_sample256[%0d]: got re=%h im=%h idx=%0d fd=%b expected re=%h im=%h idx=%0d fd=0",
                 i, q256[i].re, q256[i].im, q256[i].idx, q256[i].fd, bytes[2*i], bytes[2*i+1], i);
      end
    end
    checks++; if (re4 !== 8'sh11 || im4 !== 8'sh22) begin fails++; $display("FAIL pairs_hold: got re=%h im=%h expected re=11 im=22", re4, im4); end
  endtask

  task automatic test_glitch();
    pulse_clr();
    idle(20);
    clear_mon();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    checks++; if (q256.size() != 0 || q4.size() != 0) begin fails++; $display("FAIL glitch_valid: got %0d/%0d samples expected 0/0", q256.size(), q4.size()); end
    checks++; if (errc256 != 0 || errc4 != 0) begin fails++; $display("FAIL glitch_byte_err: got %0d/%0d expected 0/0", errc256, errc4); end
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b1);
    idle(20);
    checks++; if (q256.size() != 1) begin fails++; $display("FAIL glitch_after_count: got %0d expected 1", q256.size()); end
    if (q256.size() >= 1) begin
      checks++;
      if (q256[0].re !== 8'h5A || q256[0].im !== 8'hA5 || q256[0].idx != 0) begin
        fails++;
        $display("FAIL glitch_after_sample: got re=%h im=%h idx=%0d expected re=5a im=a5 idx=0", q256[0].re, q256[0].im, q256[0].idx);
      end
    end
  endtask

  task automatic test_stop_err();
    pulse_clr();
    idle(20);
    clear_mon();
    send_byte(8'h11, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(30);
    checks++; if (errc256 != 1) begin fails++; $display("FAIL stop_err_pulse256: got %0d cycles expected 1", errc256); end
    checks++; if (errc4 != 1) begin fails++; $display("FAIL stop_err_pulse4: got %0d cycles expected 1", errc4); end
    checks++; if (q256.size() != 0) begin fails++; $display("FAIL stop_err_no_sample: got %0d expected 0", q256.size()); end
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    idle(20);
    checks++; if (q256.size() != 2) begin fails++; $display("FAIL stop_err_count: got %0d expected 2", q256.size()); end
    if (q256.size() >= 2) begin
      checks++;
      if (q256[0].re !== 8'h11 || q256[0].im !== 8'h22 || q256[0].idx != 0) begin
        fails++;
        $display("FAIL stop_err_sample0: got re=%h im=%h idx=%0d expected re=11 im=22 idx=0", q256[0].re, q256[0].im, q256[0].idx);
      end
      checks++;
      if (q256[1].re !== 8'h33 || q256[1].im !== 8'h44 || q256[1].idx != 1) begin
        fails++;
        $display("FAIL stop_err_sample1: got re=%h im=%h idx=%0d expected re=33 im=44 idx=1", q256[1].re, q256[1].im, q256[1].idx);
      end
    end
    checks++; if (errc256 != 1) begin fails++; $display("FAIL stop_err_total: got %0d expected 1", errc256); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b = 8'hC3;
    clear_mon();
    send_byte(8'h7E, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (idx256 !== 8'd0 || v256 !== 1'b0) begin fails++; $display("FAIL reset_mid_state: got idx=%0d valid=%b expected idx=0 valid=0", idx256, v256); end
    rst_n = 1'b1;
    idle(40);
    checks++; if (q256.size() != 0) begin fails++; $display("FAIL reset_mid_partial: got %0d samples expected 0", q256.size()); end
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    idle(20);
    checks++; if (q256.size() != 1 || q4.size() != 1) begin fails++; $display("FAIL reset_mid_count: got %0d/%0d expected 1/1", q256.size(), q4.size()); end
    if (q256.size() >= 1) begin
      checks++;
      if (q256[0].re !== 8'h10 || q256[0].im !== 8'h20 || q256[0].idx != 0) begin
        fails++;
        $display("FAIL reset_mid_sample: got re=%h im=%h idx=%0d expected re=10 im=20 idx=0", q256[0].re, q256[0].im, q256[0].idx);
      end
    end
  endtask

  task automatic test_clr();
    logic [7:0]  e_re  [4] = '{8'h01, 8'h03, 8'h06, 8'h08};
    logic [7:0]  e_im  [4] = '{8'h02, 8'h04, 8'h07, 8'h09};
    int unsigned e_idx [4] = '{0, 1, 0, 1};
    pulse_clr();
    idle(20);
    clear_mon();
    for (int unsigned i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    idle(5);
    pulse_clr();
    idle(5);
    for (int unsigned i = 6; i <= 9; i++) send_byte(8'(i), 1'b1);
    idle(20);
    checks++; if (q256.size() != 4) begin fails++; $display("FAIL clr_count: got %0d expected 4", q256.size()); end
    for (int unsigned i = 0; i < 4 && i < q256.size(); i++) begin
      checks++;
      if (q256[i].re !== e_re[i] || q256[i].im !== e_im[i] || q256[i].idx != e_idx[i] || q256[i].fd !== 1'b0) begin
        fails++;
        $display("FAIL clr_sample[%0d]: got re=%h im=%h idx=%0d fd=%b expected re=%h im=%h idx=%0d fd=0",
                 i, q256[i].re, q256[i].im, q256[i].idx, q256[i].fd, e_re[i], e_im[i], e_idx[i]);
      end
    end
    checks++; if (q4.size() != 4 || (q4.size() == 4 && (q4[2].idx != 0 || q4[2].re !== 8'h06))) begin
      fails++; $display("FAIL clr_n4: got %0d samples expected 4 with sample2 re=06 idx=0", q4.size());
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_frame_256();
    test_pairs_n4();
    test_glitch();
    test_stop_err();
    test_reset_mid();
    test_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_sample_loader.md
Name: uart_rx_sample_loader

Overview:
- Synthesizable UART receiver that deserializes the 8N1 byte stream used to load FFT input data.
- Pairs consecutive bytes into complex samples: even byte = real part, odd byte = imaginary part, both signed 8-bit.
- Emits one valid pulse per complex sample with a running sample index, and flags the end of each N-sample frame.
- Sits between the board RX pin and the FFT input buffer write port.

Parameters:
- N, 256, complex samples per frame; 2*N bytes per frame; power of two.
- CLKS_PER_BIT, 10, clk cycles per UART bit; even, >= 4.
- IDX_W, $clog2(N), width of sample_idx.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_i  input  1  raw UART line, idle high, asynchronous to clk.
- clr_i  input  1  synchronous frame resync; clears pair phase and sample index.
- data_re  output  8  signed real part of the current sample.
- data_im  output  8  signed imaginary part of the current sample.
- sample_valid  output  1  one-cycle pulse; data_re, data_im and sample_idx are valid this cycle.
- sample_idx  output  IDX_W  index 0..N-1 of the sample presented.
- frame_done  output  1  one-cycle pulse coincident with sample_valid for idx N-1.
- byte_err  output  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset values:
  - data_re = data_im = 0; sample_valid = frame_done = byte_err = 0; sample_idx = 0.
  - Internal: FSM = IDLE, pair phase = real, synchronizer FFs = 1.
- Synchronizer: rx_i passes through 2 flops to give rx_s. All decisions use rx_s.
- Bit counter cnt counts 0..CLKS_PER_BIT-1. Bit index counts 0..7.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START, cnt=0.
  - START: at cnt==CLKS_PER_BIT/2-1, check rx_s. If 0 -> DATA with cnt=0 and bit index=0. If 1, it is a glitch -> IDLE with no output.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rx_s in LSB-first (bit0 first) and reset cnt. After bit 7 -> STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - If 1, the byte is accepted.
    - If 0, pulse byte_err, discard the byte, leave pair phase unchanged.
    - Either way -> IDLE the next cycle.
- Back-to-back frames: a start edge directly after a stop bit, with no idle gap, must be received. IDLE re-arms half a bit before the next start edge.
- Byte acceptance:
  - Phase real: store the byte in an internal real register; phase -> imag; no output.
  - Phase imag: the cycle after the stop sample, do all of the following:
    - drive data_re = stored real and data_im = this byte;
    - sample_valid = 1 with the current sample_idx;
    - phase -> real.
- Index update: sample_idx increments the cycle after each sample_valid. It wraps N-1 -> 0.
- frame_done = 1 in the same cycle as the sample_valid whose sample_idx == N-1.
- data_re and data_im hold their values until the next sample_valid.
- Latency: sample_valid rises 2 (sync) + 1 cycles after the rx_i sample point of the second byte's stop bit.
- clr_i:
  - When high, phase -> real and sample_idx -> 0 next cycle.
  - A byte completing in the same cycle is discarded.
  - The UART FSM is not affected.
- Reset mid-byte: all state returns to reset values immediately. A partial byte is never emitted. Reception resumes at the next valid start bit after rst_n deasserts.
- No buffering: the downstream writer must accept every sample_valid. There is no backpressure.

Test Plan:
- N=256, CLKS_PER_BIT=10, 512 back-to-back bytes 0xFF with no idle gaps -> 256 sample_valid pulses with data_re = data_im = -1 and sample_idx 0..255; exactly one frame_done, at idx 255; byte_err never set.
- N=4, bytes 0x01,0x80,0x7F,0xFE,... -> sample 0: re=+1, im=-128; sample 1: re=+127, im=-2; after the 4th sample the index wraps to 0 and the next sample is idx 0.
- Glitch: rx_i low for 3 cycles, then high -> no sample_valid, no byte_err, FSM back in IDLE; the following valid byte is still received correctly.
- Byte 0x55 sent with stop bit forced 0 -> byte_err pulses once; pair phase unchanged, so the next two good bytes form one sample at an unchanged index.
- rst_n low during bit 4 of an imaginary byte, then 2 new bytes 0x10,0x20 -> a single sample_valid with re=0x10, im=0x20, idx 0.
- clr_i pulsed after the real byte of sample 2 -> the next two bytes are emitted as idx 0 with the correct re/im split.
